// File: rtl/ysyx_22040895_trap_ctrl.sv
// Trap/mret sequencer driving the trap-side CSR strobes and issuing a one-cycle PC redirect.
// Optional vectored-mode target when YSYX_22040895_TRAP_VECTORED_EN is defined.
module ysyx_22040895_trap_ctrl #(
  parameter int         XLEN  = 64,
  parameter logic [1:0] MPP_M = 2'b11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic            mret_i,
  output logic            busy_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            set_mepc_o,
  output logic            set_mcause_o,
  output logic            set_mstatus_o,
  output logic            get_mepc_o,
  output logic            get_mtvec_o,
  output logic            get_mstatus_o,
  output logic [XLEN-1:0] wdata_mepc_o,
  output logic [XLEN-1:0] wdata_mcause_o,
  output logic [XLEN-1:0] wdata_mstatus_o,
  input  logic [XLEN-1:0] rdata_mepc_i,
  input  logic [XLEN-1:0] rdata_mtvec_i,
  input  logic [XLEN-1:0] rdata_mstatus_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T_SAVE = 3'd1,
    T_STAT = 3'd2,
    T_VEC  = 3'd3,
    R_STAT = 3'd4,
    R_PC   = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] cap_pc;
  logic [XLEN-1:0] cap_cause;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] trap_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cap_pc    <= '0;
      cap_cause <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && trap_i) begin
        cap_pc    <= trap_pc_i;
        cap_cause <= trap_cause_i;
      end
    end
  end

  assign busy_o     = (state != IDLE);
  assign mtvec_base = {rdata_mtvec_i[XLEN-1:2], 2'b00};

`ifdef YSYX_22040895_TRAP_VECTORED_EN
  // Vectored interrupts land at base + 4*cause; exceptions still use the base.
  always_comb begin
    trap_target = mtvec_base;
    if (rdata_mtvec_i[1:0] == 2'b01 && cap_cause[XLEN-1])
      trap_target = mtvec_base + {cap_cause[XLEN-3:0], 2'b00};
  end
`else
  assign trap_target = mtvec_base;
`endif

  always_comb begin
    state_nxt       = state;
    redirect_o      = 1'b0;
    redirect_pc_o   = '0;
    set_mepc_o      = 1'b0;
    set_mcause_o    = 1'b0;
    set_mstatus_o   = 1'b0;
    get_mepc_o      = 1'b0;
    get_mtvec_o     = 1'b0;
    get_mstatus_o   = 1'b0;
    wdata_mepc_o    = '0;
    wdata_mcause_o  = '0;
    wdata_mstatus_o = '0;
    case (state)
      IDLE: begin
        // A trap wins over a simultaneous mret; the mret is simply dropped.
        if (trap_i)      state_nxt = T_SAVE;
        else if (mret_i) state_nxt = R_STAT;
      end
      T_SAVE: begin
        set_mepc_o     = 1'b1;
        wdata_mepc_o   = {cap_pc[XLEN-1:2], 2'b00};
        set_mcause_o   = 1'b1;
        wdata_mcause_o = cap_cause;
        state_nxt      = T_STAT;
      end
      T_STAT: begin
        get_mstatus_o         = 1'b1;
        set_mstatus_o         = 1'b1;
        wdata_mstatus_o       = rdata_mstatus_i;
        wdata_mstatus_o[7]    = rdata_mstatus_i[3];
        wdata_mstatus_o[3]    = 1'b0;
        wdata_mstatus_o[12:11] = MPP_M;
        state_nxt             = T_VEC;
      end
      T_VEC: begin
        get_mtvec_o   = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = trap_target;
        state_nxt     = IDLE;
      end
      R_STAT: begin
        get_mstatus_o         = 1'b1;
        set_mstatus_o         = 1'b1;
        wdata_mstatus_o       = rdata_mstatus_i;
        wdata_mstatus_o[3]    = rdata_mstatus_i[7];
        wdata_mstatus_o[7]    = 1'b1;
        wdata_mstatus_o[12:11] = MPP_M;
        state_nxt             = R_PC;
      end
      R_PC: begin
        get_mepc_o    = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = rdata_mepc_i;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040895_trap_ctrl.sv
// Bench for ysyx_22040895_trap_ctrl: per-cycle comparison against a queue of expected output cycles,
// plus literal checks on captured CSR writes and redirect targets.
module tb_ysyx_22040895_trap_ctrl;
  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            trap_i;
  logic [XLEN-1:0] trap_pc_i;
  logic [XLEN-1:0] trap_cause_i;
  logic            mret_i;
  logic            busy_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            set_mepc_o, set_mcause_o, set_mstatus_o;
  logic            get_mepc_o, get_mtvec_o, get_mstatus_o;
  logic [XLEN-1:0] wdata_mepc_o, wdata_mcause_o, wdata_mstatus_o;
  logic [XLEN-1:0] rdata_mepc_i, rdata_mtvec_i, rdata_mstatus_i;

  // CSR file contents presented to the DUT; set directly by the stimulus
  logic [XLEN-1:0] csr_mepc, csr_mtvec, csr_mstatus;

  assign rdata_mepc_i    = get_mepc_o    ? csr_mepc    : '0;
  assign rdata_mtvec_i   = get_mtvec_o   ? csr_mtvec   : '0;
  assign rdata_mstatus_i = get_mstatus_o ? csr_mstatus : '0;

  ysyx_22040895_trap_ctrl #(.XLEN(XLEN), .MPP_M(2'b11)) dut (
    .clk(clk), .rst(rst), .trap_i(trap_i), .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
    .mret_i(mret_i), .busy_o(busy_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .set_mepc_o(set_mepc_o), .set_mcause_o(set_mcause_o), .set_mstatus_o(set_mstatus_o),
    .get_mepc_o(get_mepc_o), .get_mtvec_o(get_mtvec_o), .get_mstatus_o(get_mstatus_o),
    .wdata_mepc_o(wdata_mepc_o), .wdata_mcause_o(wdata_mcause_o), .wdata_mstatus_o(wdata_mstatus_o),
    .rdata_mepc_i(rdata_mepc_i), .rdata_mtvec_i(rdata_mtvec_i), .rdata_mstatus_i(rdata_mstatus_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic seen_reset = 1'b0;
  always @(posedge clk) if (rst) seen_reset <= 1'b1;

  // expected outputs for one cycle
  typedef struct packed {
    logic            busy;
    logic            redir;
    logic [XLEN-1:0] rpc;
    logic            sm, sc, ss, gm, gt, gs;
    logic [XLEN-1:0] wm, wc, ws;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  function automatic logic [XLEN-1:0] m_trap_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = s & ~(64'h1888);
    if (s[3]) r = r | 64'h80;
    return r | 64'h1800;
  endfunction

  function automatic logic [XLEN-1:0] m_mret_status(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r = (s & ~(64'h1888)) | 64'h1880;
    if (s[7]) r = r | 64'h8;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] m_target(input logic [XLEN-1:0] tvec, input logic [XLEN-1:0] cause);
    logic [XLEN-1:0] base;
    base = tvec & ~64'h3;
`ifdef YSYX_22040895_TRAP_VECTORED_EN
    if ((tvec & 64'h3) == 64'h1 && cause[XLEN-1])
      return base + 4 * (cause & ~(64'h1 << (XLEN-1)));
`endif
    return base;
  endfunction

  // observed-write record, written only by the compare process
  int              cnt_mepc_w = 0, cnt_stat_w = 0, cnt_redir = 0, cnt_busy = 0;
  logic [XLEN-1:0] last_wm = '0, last_wc = '0, last_ws = '0, last_rpc = '0;

  // compare process: every cycle after the first reset edge
  always @(negedge clk) begin
    exp_t e;
    logic was_idle;
    if (seen_reset) begin
      was_idle = (exp_q.size() == 0);
      e = '0;
      if (!was_idle) e = exp_q[0];
      check("busy",        {63'b0, busy_o},        {63'b0, e.busy});
      check("redirect",    {63'b0, redirect_o},    {63'b0, e.redir});
      check("redirect_pc", redirect_pc_o,          e.rpc);
      check("set_mepc",    {63'b0, set_mepc_o},    {63'b0, e.sm});
      check("set_mcause",  {63'b0, set_mcause_o},  {63'b0, e.sc});
      check("set_mstatus", {63'b0, set_mstatus_o}, {63'b0, e.ss});
      check("get_mepc",    {63'b0, get_mepc_o},    {63'b0, e.gm});
      check("get_mtvec",   {63'b0, get_mtvec_o},   {63'b0, e.gt});
      check("get_mstatus", {63'b0, get_mstatus_o}, {63'b0, e.gs});
      check("wdata_mepc",    wdata_mepc_o,    e.wm);
      check("wdata_mcause",  wdata_mcause_o,  e.wc);
      check("wdata_mstatus", wdata_mstatus_o, e.ws);
      if (busy_o)        cnt_busy++;
      if (set_mepc_o)    begin cnt_mepc_w++; last_wm = wdata_mepc_o; last_wc = wdata_mcause_o; end
      if (set_mstatus_o) begin cnt_stat_w++; last_ws = wdata_mstatus_o; end
      if (redirect_o)    begin cnt_redir++; last_rpc = redirect_pc_o; end
      if (!was_idle) void'(exp_q.pop_front());
      if (rst) begin
        exp_q.delete();
      end else if (was_idle && trap_i) begin
        e = '0; e.busy = 1; e.sm = 1; e.sc = 1;
        e.wm = trap_pc_i & ~64'h3; e.wc = trap_cause_i;
        exp_q.push_back(e);
        e = '0; e.busy = 1; e.gs = 1; e.ss = 1; e.ws = m_trap_status(csr_mstatus);
        exp_q.push_back(e);
        e = '0; e.busy = 1; e.gt = 1; e.redir = 1; e.rpc = m_target(csr_mtvec, trap_cause_i);
        exp_q.push_back(e);
      end else if (was_idle && mret_i) begin
        e = '0; e.busy = 1; e.gs = 1; e.ss = 1; e.ws = m_mret_status(csr_mstatus);
        exp_q.push_back(e);
        e = '0; e.busy = 1; e.gm = 1; e.redir = 1; e.rpc = csr_mepc;
        exp_q.push_back(e);
      end
    end
  end

  // driver tasks
  task automatic pulse(input logic t, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] cause, input logic m);
    @(posedge clk); #1;
    trap_i = t; trap_pc_i = pc; trap_cause_i = cause; mret_i = m;
    @(posedge clk); #1;
    trap_i = 0; trap_pc_i = '0; trap_cause_i = '0; mret_i = 0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) begin done = 1; break; end
    end
    check("wait_idle_timeout", {63'b0, done}, 64'd1);
  endtask

  int b_busy, b_redir, b_mepc, b_stat;
  task automatic snap();
    b_busy = cnt_busy; b_redir = cnt_redir; b_mepc = cnt_mepc_w; b_stat = cnt_stat_w;
  endtask

  initial begin
    rst = 1; trap_i = 0; trap_pc_i = '0; trap_cause_i = '0; mret_i = 0;
    csr_mepc = '0; csr_mtvec = '0; csr_mstatus = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_busy", {63'b0, busy_o}, 64'd0);
    check("reset_redirect", {63'b0, redirect_o}, 64'd0);

    // plain ecall
    csr_mtvec = 64'h80001000; csr_mstatus = 64'h8;
    snap();
    pulse(1, 64'h80000104, 64'd11, 0);
    wait_idle();
    check("t1_mepc", last_wm, 64'h80000104);
    check("t1_mcause", last_wc, 64'd11);
    check("t1_mstatus", last_ws, 64'h1880);
    check("t1_target", last_rpc, 64'h80001000);
    check("t1_busy_cycles", 64'(cnt_busy - b_busy), 64'd3);
    check("t1_redirects", 64'(cnt_redir - b_redir), 64'd1);

    // mret
    csr_mepc = 64'h80000108; csr_mstatus = 64'h1880;
    snap();
    pulse(0, '0, '0, 1);
    wait_idle();
    check("t2_mstatus", last_ws, 64'h1888);
    check("t2_target", last_rpc, 64'h80000108);
    check("t2_busy_cycles", 64'(cnt_busy - b_busy), 64'd2);

    // trap and mret together: trap only
    csr_mstatus = 64'h80; csr_mtvec = 64'h80001000;
    snap();
    pulse(1, 64'h80000200, 64'd3, 1);
    wait_idle();
    check("t3_mstatus", last_ws, 64'h1800);
    check("t3_stat_writes", 64'(cnt_stat_w - b_stat), 64'd1);
    check("t3_redirects", 64'(cnt_redir - b_redir), 64'd1);
    check("t3_target", last_rpc, 64'h80001000);

    // second trap while busy is ignored
    snap();
    pulse(1, 64'h80000300, 64'd2, 0);
    #1 trap_i = 1; trap_pc_i = 64'h80000400; trap_cause_i = 64'd5;
    @(posedge clk); #1 trap_i = 0; trap_pc_i = '0; trap_cause_i = '0;
    wait_idle();
    check("t4_mepc_writes", 64'(cnt_mepc_w - b_mepc), 64'd1);
    check("t4_redirects", 64'(cnt_redir - b_redir), 64'd1);
    check("t4_mepc", last_wm, 64'h80000300);

    // reset during T_STAT aborts the sequence
    snap();
    pulse(1, 64'h80000500, 64'd4, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("t5_busy_after_rst", {63'b0, busy_o}, 64'd0);
    check("t5_set_mstatus_after_rst", {63'b0, set_mstatus_o}, 64'd0);
    repeat (4) @(posedge clk);
    check("t5_redirects", 64'(cnt_redir - b_redir), 64'd0);

    // unaligned pc, interrupt cause with direct mtvec
    csr_mtvec = 64'h80002000; csr_mstatus = 64'h0;
    pulse(1, 64'h80000207, 64'h800000000000000B, 0);
    wait_idle();
    check("t6_mepc_aligned", last_wm, 64'h80000204);
    check("t6_target", last_rpc, 64'h80002000);

    // vectored-mode mtvec
    csr_mtvec = 64'h80001001;
    pulse(1, 64'h80000600, 64'h8000000000000007, 0);
    wait_idle();
`ifdef YSYX_22040895_TRAP_VECTORED_EN
    check("t7_target", last_rpc, 64'h8000101C);
`else
    check("t7_target", last_rpc, 64'h80001000);
`endif

    // exception with vectored mtvec still uses the base
    pulse(1, 64'h80000700, 64'd2, 0);
    wait_idle();
    check("t8_target", last_rpc, 64'h80001000);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
